vscale_htif_tohost_monitor: RTL and testbench
=============================================

Name: vscale_htif_tohost_monitor

Overview:
Host-side HTIF PCR master that drives the core's htif_pcr request/response ports in the test harness. It periodically reads the tohost CSR and decodes a nonzero value as test completion: 1 means pass, any other value means fail with code value>>1. After a completion it clears tohost with a PCR write and raises done/pass. It replaces ad-hoc testbench polling so pass/fail detection is cycle-accurate and synthesizable.

Parameters:
CSR_ADDR_WIDTH, 12, PCR address width; matches the harness CSR address width.
HTIF_PCR_WIDTH, 64, PCR data width.
TOHOST_ADDR, 12'h780, CSR address polled for completion.
POLL_INTERVAL, 16, idle cycles between consecutive tohost reads; minimum 1.
TIMEOUT_CYCLES, 1000000, cycles before a timeout is declared (optional feature only).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms the monitor
pcr_req_valid  out  1  PCR request valid
pcr_req_ready  in  1  PCR request ready
pcr_req_rw  out  1  1 = write, 0 = read
pcr_req_addr  out  CSR_ADDR_WIDTH  PCR address; always TOHOST_ADDR
pcr_req_data  out  HTIF_PCR_WIDTH  write data; always 0
pcr_resp_valid  in  1  PCR response valid
pcr_resp_ready  out  1  PCR response ready
pcr_resp_data  in  HTIF_PCR_WIDTH  PCR response data
busy  out  1  armed and not yet done
done  out  1  sticky; completion seen
pass  out  1  sticky; valid when done=1; 1 iff tohost==1
fail_code  out  HTIF_PCR_WIDTH-1  tohost>>1, captured at completion
timeout  out  1  sticky timeout flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, active-low, outputs valid immediately): state IDLE; pcr_req_valid=0, pcr_req_rw=0, pcr_resp_ready=0, busy=0, done=0, pass=0, fail_code=0, timeout=0; wait counter=0.
- States: IDLE, WAIT, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE: start=1 -> WAIT with the counter loaded to POLL_INTERVAL-1; busy=1.
- WAIT: counter decrements each cycle; at 0 -> RD_REQ.
- RD_REQ: pcr_req_valid=1, rw=0. Valid holds and address/data stay stable until a cycle with pcr_req_ready=1, which is the accept; then -> RD_RESP.
- RD_RESP: pcr_resp_ready=1. On pcr_resp_valid: if data==0 -> WAIT with the counter reloaded; else capture pass=(data==1) and fail_code=data[W-1:1], then -> WR_REQ.
- WR_REQ: pcr_req_valid=1, rw=1, data=0. On accept -> WR_RESP.
- WR_RESP: pcr_resp_ready=1. The response is consumed and its data ignored; then -> DONE and done=1.
- DONE: busy=0. Outputs hold until reset. start is ignored.
- pcr_req_valid is never deasserted before acceptance. At most one outstanding request at any time.
- A response arriving in a state other than RD_RESP or WR_RESP is never consumed (pcr_resp_ready=0).
- start while busy is ignored.
- Request and response in the same cycle cannot occur, because requests and responses are strictly sequential.
- All outputs are registered.

Optional Feature:
HTIF_MON_TIMEOUT_EN
- Defined: a 32-bit cycle counter runs from start and clears on reset.
  - When it reaches TIMEOUT_CYCLES in WAIT, RD_REQ or RD_RESP, the FSM waits for any in-flight request to be accepted and its response to be consumed.
  - It then enters DONE with timeout=1, done=1, pass=0, fail_code=0.
  - The counter saturates at its maximum value.
- Undefined: no counter is instantiated; timeout is tied to 0; the monitor polls indefinitely.

Test Plan:
1. Pulse start with pcr_req_ready=1 and the response returning 0 one cycle after each request -> reads repeat every POLL_INTERVAL+3 cycles; done stays 0.
2. tohost returns 0 twice, then 1 -> one write to 0x780 with data 0 follows; done=1, pass=1, fail_code=0.
3. tohost returns 0x7 -> done=1, pass=0, fail_code=3; the clear write is issued exactly once.
4. Hold pcr_req_ready=0 for 5 cycles during RD_REQ -> valid, rw and addr stay stable all 5 cycles; exactly one read is accepted.
5. Deassert resetn asynchronously mid-RD_RESP -> all outputs return to reset values without a clock edge; the next start restarts polling.
6. With HTIF_MON_TIMEOUT_EN and TIMEOUT_CYCLES=100, tohost always 0 -> timeout=1, done=1, pass=0 within 100+POLL_INTERVAL+3 cycles of start.

Source files
------------

// File: rtl/vscale_htif_tohost_monitor.sv
// Host-side HTIF PCR master: polls tohost, decodes pass/fail, clears tohost, then raises done.
// Optional cycle-budget timeout is enabled by defining HTIF_MON_TIMEOUT_EN.
module vscale_htif_tohost_monitor #(
    parameter int                        CSR_ADDR_WIDTH = 12,
    parameter int                        HTIF_PCR_WIDTH = 64,
    parameter logic [CSR_ADDR_WIDTH-1:0] TOHOST_ADDR    = 12'h780,
    parameter int                        POLL_INTERVAL  = 16,
    parameter int                        TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    output logic                      pcr_req_valid,
    input  logic                      pcr_req_ready,
    output logic                      pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0] pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0] pcr_req_data,
    input  logic                      pcr_resp_valid,
    output logic                      pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0] pcr_resp_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [HTIF_PCR_WIDTH-2:0] fail_code,
    output logic                      timeout
);

    localparam int WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [WAIT_W-1:0]         WAIT_LOAD = WAIT_W'(POLL_INTERVAL - 1);
    localparam logic [WAIT_W-1:0]         WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [HTIF_PCR_WIDTH-1:0] DATA_ZERO = {HTIF_PCR_WIDTH{1'b0}};
    localparam logic [HTIF_PCR_WIDTH-1:0] DATA_ONE  = {{(HTIF_PCR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HTIF_PCR_WIDTH-2:0] CODE_ZERO = {(HTIF_PCR_WIDTH-1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_RESP = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                      state_r, state_s;
    logic [WAIT_W-1:0]           wait_r, wait_s;
    logic                        pass_r, pass_s;
    logic                        done_r, done_s;
    logic [HTIF_PCR_WIDTH-2:0]   fail_code_r, fail_code_s;
    logic                        req_valid_r, req_rw_r, resp_ready_r, busy_r;
    logic                        req_fire_s, resp_fire_s;
    logic                        to_hit_s;

    assign req_fire_s  = req_valid_r & pcr_req_ready;
    assign resp_fire_s = pcr_resp_valid & resp_ready_r;

    // Next-state and captured-result logic; a timeout only lands where no transaction is in flight.
    always_comb begin
        state_s     = state_r;
        wait_s      = wait_r;
        pass_s      = pass_r;
        done_s      = done_r;
        fail_code_s = fail_code_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_WAIT;
                    wait_s  = WAIT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (to_hit_s) begin
                    state_s     = ST_DONE;
                    done_s      = 1'b1;
                    pass_s      = 1'b0;
                    fail_code_s = CODE_ZERO;
                end else if (wait_r == WAIT_ZERO) begin
                    state_s = ST_RD_REQ;
                end else begin
                    wait_s = wait_r - {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_REQ: begin
                if (req_fire_s) begin
                    state_s = ST_RD_RESP;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (resp_fire_s) begin
                    if (to_hit_s) begin
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                        pass_s      = 1'b0;
                        fail_code_s = CODE_ZERO;
                    end else if (pcr_resp_data == DATA_ZERO) begin
                        state_s = ST_WAIT;
                        wait_s  = WAIT_LOAD;
                    end else begin
                        state_s     = ST_WR_REQ;
                        pass_s      = (pcr_resp_data == DATA_ONE);
                        fail_code_s = pcr_resp_data[HTIF_PCR_WIDTH-1:1];
                    end
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            ST_WR_REQ: begin
                if (req_fire_s) begin
                    state_s = ST_WR_RESP;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (resp_fire_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, results and all handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            wait_r       <= WAIT_ZERO;
            pass_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_code_r  <= CODE_ZERO;
            req_valid_r  <= 1'b0;
            req_rw_r     <= 1'b0;
            resp_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            wait_r       <= wait_s;
            pass_r       <= pass_s;
            done_r       <= done_s;
            fail_code_r  <= fail_code_s;
            req_valid_r  <= (state_s == ST_RD_REQ) || (state_s == ST_WR_REQ);
            req_rw_r     <= (state_s == ST_WR_REQ);
            resp_ready_r <= (state_s == ST_RD_RESP) || (state_s == ST_WR_RESP);
            busy_r       <= (state_s != ST_IDLE) && (state_s != ST_DONE);
        end
    end

`ifdef HTIF_MON_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0] to_cnt_r;
    logic        timeout_r;

    assign to_hit_s = (to_cnt_r >= TO_LIMIT);

    // Cycles since start, saturating so a very long run cannot wrap back under the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_r <= 32'd0;
        end else if (state_r == ST_IDLE) begin
            to_cnt_r <= 32'd0;
        end else if ((state_r != ST_DONE) && (to_cnt_r != 32'hFFFF_FFFF)) begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Timeout flag mirrors the two FSM exits that take the timeout path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_r <= 1'b0;
        end else if (to_hit_s && ((state_r == ST_WAIT) ||
                                  ((state_r == ST_RD_RESP) && resp_fire_s))) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    assign to_hit_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign pcr_req_valid  = req_valid_r;
    assign pcr_req_rw     = req_rw_r;
    assign pcr_req_addr   = TOHOST_ADDR;
    assign pcr_req_data   = DATA_ZERO;
    assign pcr_resp_ready = resp_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign fail_code      = fail_code_r;

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Directed bench for vscale_htif_tohost_monitor with a small PCR host-side responder model.
module tb_vscale_htif_tohost_monitor;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int P  = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          pcr_req_valid;
    logic          pcr_req_ready;
    logic          pcr_req_rw;
    logic [AW-1:0] pcr_req_addr;
    logic [DW-1:0] pcr_req_data;
    logic          pcr_resp_valid;
    logic          pcr_resp_ready;
    logic [DW-1:0] pcr_resp_data;
    logic          busy, done, pass, timeout;
    logic [DW-2:0] fail_code;

    int total = 0;
    int bad   = 0;

    // host model state
    int            cyc;
    int            nreads, nwrites;
    int            read_cyc[$];
    logic [DW-1:0] tohost_q[$];
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          resp_pend, pend_is_read;
    int            resp_cnt;

    vscale_htif_tohost_monitor #(
        .CSR_ADDR_WIDTH(AW), .HTIF_PCR_WIDTH(DW), .TOHOST_ADDR(12'h780),
        .POLL_INTERVAL(P), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready),
        .pcr_req_rw(pcr_req_rw), .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
        .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready),
        .pcr_resp_data(pcr_resp_data),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        cyc = 0; nreads = 0; nwrites = 0;
        read_cyc.delete(); tohost_q.delete();
        rd_addr = '0; wr_addr = '0; wr_data = '1;
        resp_pend = 1'b0; pend_is_read = 1'b0; resp_cnt = 0;
        pcr_resp_valid = 1'b0; pcr_resp_data = '0;
    endtask

    // One clock: record handshakes seen before the edge, then drive the responder after it.
    task automatic step();
        logic          req_acc, resp_acc, acc_rw;
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_data;
        req_acc  = pcr_req_valid && pcr_req_ready;
        acc_rw   = pcr_req_rw;
        acc_addr = pcr_req_addr;
        acc_data = pcr_req_data;
        resp_acc = pcr_resp_valid && pcr_resp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (resp_acc) begin
            pcr_resp_valid = 1'b0;
            pcr_resp_data  = '0;
            resp_pend      = 1'b0;
        end
        if (req_acc) begin
            if (acc_rw) begin
                nwrites++; wr_addr = acc_addr; wr_data = acc_data;
            end else begin
                nreads++; rd_addr = acc_addr; read_cyc.push_back(cyc);
            end
            resp_pend = 1'b1; resp_cnt = 1; pend_is_read = !acc_rw;
        end
        if (resp_pend && !pcr_resp_valid) begin
            if (resp_cnt == 0) begin
                pcr_resp_valid = 1'b1;
                if (!pend_is_read) pcr_resp_data = 64'hDEAD_BEEF;
                else if (tohost_q.size() > 0) pcr_resp_data = tohost_q.pop_front();
                else pcr_resp_data = 64'd0;
            end else begin
                resp_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; pcr_req_ready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && !done; i++) step();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL %s_done_wait: got done=%0b required 1 within %0d cycles", name, done, budget); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; pcr_req_ready = 1'b1;
        clear_model();
        #1;
        total++; if (pcr_req_valid !== 1'b0)  begin bad++; $display("FAIL rst_req_valid: got %0b required 0", pcr_req_valid); end
        total++; if (pcr_req_rw !== 1'b0)     begin bad++; $display("FAIL rst_req_rw: got %0b required 0", pcr_req_rw); end
        total++; if (pcr_resp_ready !== 1'b0) begin bad++; $display("FAIL rst_resp_ready: got %0b required 0", pcr_resp_ready); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy: got %0b required 0", busy); end
        total++; if (done !== 1'b0)           begin bad++; $display("FAIL rst_done: got %0b required 0", done); end
        total++; if (pass !== 1'b0)           begin bad++; $display("FAIL rst_pass: got %0b required 0", pass); end
        total++; if (fail_code !== '0)        begin bad++; $display("FAIL rst_fail_code: got %0h required 0", fail_code); end
        total++; if (timeout !== 1'b0)        begin bad++; $display("FAIL rst_timeout: got %0b required 0", timeout); end
        total++; if (pcr_req_addr !== 12'h780) begin bad++; $display("FAIL rst_addr: got %0h required 780", pcr_req_addr); end
    endtask

    task automatic test_poll();
        int s;
        do_reset();
        pulse_start();
        s = cyc;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL poll_busy_after_start: got %0b required 1", busy); end
        for (int i = 0; i < 50 && nreads < 1; i++) step();
        pulse_start();
        for (int i = 0; i < 100 && nreads < 3; i++) step();
        total++;
        if (nreads < 3) begin
            bad++; $display("FAIL poll_read_count: got %0d required 3", nreads);
        end else begin
            if (read_cyc[0] - s !== P + 1) begin bad++; $display("FAIL poll_first_latency: got %0d required %0d", read_cyc[0] - s, P + 1); end
            total++;
            if (read_cyc[1] - read_cyc[0] !== P + 3) begin bad++; $display("FAIL poll_period_1: got %0d required %0d", read_cyc[1] - read_cyc[0], P + 3); end
            total++;
            if (read_cyc[2] - read_cyc[1] !== P + 3) begin bad++; $display("FAIL poll_period_2: got %0d required %0d", read_cyc[2] - read_cyc[1], P + 3); end
        end
        total++; if (rd_addr !== 12'h780) begin bad++; $display("FAIL poll_rd_addr: got %0h required 780", rd_addr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL poll_done: got %0b required 0", done); end
        total++; if (nwrites !== 0) begin bad++; $display("FAIL poll_no_write: got %0d required 0", nwrites); end
    endtask

    task automatic test_pass();
        do_reset();
        tohost_q.push_back(64'd0); tohost_q.push_back(64'd0); tohost_q.push_back(64'd1);
        pulse_start();
        wait_done(200, "pass");
        total++; if (nreads !== 3)        begin bad++; $display("FAIL pass_reads: got %0d required 3", nreads); end
        total++; if (nwrites !== 1)       begin bad++; $display("FAIL pass_writes: got %0d required 1", nwrites); end
        total++; if (wr_addr !== 12'h780) begin bad++; $display("FAIL pass_wr_addr: got %0h required 780", wr_addr); end
        total++; if (wr_data !== 64'd0)   begin bad++; $display("FAIL pass_wr_data: got %0h required 0", wr_data); end
        total++; if (pass !== 1'b1)       begin bad++; $display("FAIL pass_flag: got %0b required 1", pass); end
        total++; if (fail_code !== '0)    begin bad++; $display("FAIL pass_fail_code: got %0h required 0", fail_code); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL pass_busy: got %0b required 0", busy); end
        total++; if (timeout !== 1'b0)    begin bad++; $display("FAIL pass_timeout: got %0b required 0", timeout); end
    endtask

    task automatic test_fail();
        do_reset();
        tohost_q.push_back(64'd7);
        pulse_start();
        wait_done(100, "fail");
        total++; if (pass !== 1'b0)          begin bad++; $display("FAIL fail_pass: got %0b required 0", pass); end
        total++; if (fail_code !== 63'd3)    begin bad++; $display("FAIL fail_code: got %0h required 3", fail_code); end
        repeat (20) step();
        pulse_start();
        repeat (10) step();
        total++; if (nwrites !== 1)          begin bad++; $display("FAIL fail_single_write: got %0d required 1", nwrites); end
        total++; if (nreads !== 1)           begin bad++; $display("FAIL fail_single_read: got %0d required 1", nreads); end
        total++; if (done !== 1'b1)          begin bad++; $display("FAIL fail_done_hold: got %0b required 1", done); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL fail_busy_after_start: got %0b required 0", busy); end
        total++; if (pcr_req_valid !== 1'b0) begin bad++; $display("FAIL fail_req_idle: got %0b required 0", pcr_req_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        pcr_req_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && !pcr_req_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            total++; if (pcr_req_valid !== 1'b1)  begin bad++; $display("FAIL bp_valid_%0d: got %0b required 1", i, pcr_req_valid); end
            total++; if (pcr_req_rw !== 1'b0)     begin bad++; $display("FAIL bp_rw_%0d: got %0b required 0", i, pcr_req_rw); end
            total++; if (pcr_req_addr !== 12'h780) begin bad++; $display("FAIL bp_addr_%0d: got %0h required 780", i, pcr_req_addr); end
            step();
        end
        total++; if (nreads !== 0) begin bad++; $display("FAIL bp_no_accept: got %0d required 0", nreads); end
        pcr_req_ready = 1'b1;
        step();
        pcr_req_ready = 1'b0;
        repeat (12) step();
        total++; if (nreads !== 1) begin bad++; $display("FAIL bp_one_accept: got %0d required 1", nreads); end
        total++; if (pcr_req_valid !== 1'b1) begin bad++; $display("FAIL bp_next_read_held: got %0b required 1", pcr_req_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        for (int i = 0; i < 50 && !pcr_resp_ready; i++) step();
        total++; if (pcr_resp_ready !== 1'b1) begin bad++; $display("FAIL ar_reach_rd_resp: got %0b required 1", pcr_resp_ready); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (pcr_resp_ready !== 1'b0) begin bad++; $display("FAIL ar_resp_ready: got %0b required 0", pcr_resp_ready); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL ar_busy: got %0b required 0", busy); end
        total++; if (pcr_req_valid !== 1'b0)  begin bad++; $display("FAIL ar_req_valid: got %0b required 0", pcr_req_valid); end
        total++; if (done !== 1'b0)           begin bad++; $display("FAIL ar_done: got %0b required 0", done); end
        clear_model();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && nreads < 1; i++) step();
        total++; if (nreads !== 1) begin bad++; $display("FAIL ar_restart_read: got %0d required 1", nreads); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_restart_busy: got %0b required 1", busy); end
    endtask

`ifdef HTIF_MON_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        pulse_start();
        wait_done(TO + P + 3, "to");
        total++; if (timeout !== 1'b1)    begin bad++; $display("FAIL to_flag: got %0b required 1", timeout); end
        total++; if (pass !== 1'b0)       begin bad++; $display("FAIL to_pass: got %0b required 0", pass); end
        total++; if (fail_code !== '0)    begin bad++; $display("FAIL to_fail_code: got %0h required 0", fail_code); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL to_busy: got %0b required 0", busy); end
        total++; if (nwrites !== 0)       begin bad++; $display("FAIL to_no_write: got %0d required 0", nwrites); end
    endtask
`endif

    initial begin
        test_reset();
        test_poll();
        test_pass();
        test_fail();
        test_backpressure();
        test_async_reset();
`ifdef HTIF_MON_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
